// File: rtl/in_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : in_scan_ctrl
// Description : Sequencer for a 16-port input multiplexer. Runs a round-robin
//               background scan, keeps a shadow copy of each port's value,
//               and flags per-port changes as pending interrupts. Direct CPU
//               reads share the mux and take priority over the scan.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               scan_en, mask     - scan enable, per-port change-watch enable
//               bus_enable/addr   - drive the mux select
//               bus_data          - mux output bus
//               cpu_req/addr      - CPU direct-read request (level) and port
//               cpu_grant/data    - one-cycle grant pulse, captured read value
//               pending, irq      - per-port change flags and their OR
//               irq_port/data     - lowest pending port and its shadow value
//               ack               - clears pending[irq_port]
// Revision    : 1.0 - initial release
// ============================================================================
module in_scan_ctrl #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int NPORTS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic [NPORTS-1:0] mask,
    output logic              bus_enable,
    output logic [AW-1:0]     bus_addr,
    input  logic [DW-1:0]     bus_data,
    input  logic              cpu_req,
    input  logic [AW-1:0]     cpu_addr,
    output logic              cpu_grant,
    output logic [DW-1:0]     cpu_data,
    output logic [NPORTS-1:0] pending,
    output logic              irq,
    output logic [AW-1:0]     irq_port,
    output logic [DW-1:0]     irq_data,
    input  logic              ack
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SDRV = 3'd1;
    localparam logic [2:0] S_SSMP = 3'd2;
    localparam logic [2:0] S_CDRV = 3'd3;
    localparam logic [2:0] S_CSMP = 3'd4;

    logic [2:0]        state_q,     state_d;
    logic [AW-1:0]     ptr_q,       ptr_d;
    logic [AW-1:0]     bus_addr_q,  bus_addr_d;
    logic [DW-1:0]     cpu_data_q,  cpu_data_d;
    logic              cpu_grant_q, cpu_grant_d;
    logic [NPORTS-1:0] pending_q,   pending_d;
    logic [NPORTS-1:0] primed_q,    primed_d;
    logic [DW-1:0]     shadow_q [NPORTS];
    logic [DW-1:0]     shadow_d [NPORTS];
    logic [AW-1:0]     irq_port_w;

    // Lowest-index pending port: scan downward so the last hit is the lowest.
    always_comb begin
        irq_port_w = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                irq_port_w = AW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        bus_addr_d  = bus_addr_q;
        cpu_data_d  = cpu_data_q;
        cpu_grant_d = 1'b0;
        shadow_d    = shadow_q;
        primed_d    = primed_q;
        // Unwatched ports drop any pending flag on the next edge.
        pending_d   = pending_q & mask;

        if (ack && (pending_q != '0)) begin
            pending_d[irq_port_w] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // The grant cycle ignores cpu_req so a still-held request
                // does not start a second read.
                if (cpu_req && !cpu_grant_q) begin
                    bus_addr_d = cpu_addr;
                    state_d    = S_CDRV;
                end else if (scan_en) begin
                    bus_addr_d = ptr_q;
                    state_d    = S_SDRV;
                end
            end
            S_SDRV: state_d = S_SSMP;
            S_SSMP: begin
                shadow_d[ptr_q] = bus_data;
                primed_d[ptr_q] = 1'b1;
                // Set is applied after the ack clear so it wins on a tie.
                if (primed_q[ptr_q] && mask[ptr_q] &&
                    (bus_data != shadow_q[ptr_q])) begin
                    pending_d[ptr_q] = 1'b1;
                end
                if (ptr_q == AW'(NPORTS - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            S_CDRV: state_d = S_CSMP;
            S_CSMP: begin
                cpu_data_d  = bus_data;
                cpu_grant_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            bus_addr_q  <= '0;
            cpu_data_q  <= '0;
            cpu_grant_q <= 1'b0;
            pending_q   <= '0;
            primed_q    <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            bus_addr_q  <= bus_addr_d;
            cpu_data_q  <= cpu_data_d;
            cpu_grant_q <= cpu_grant_d;
            pending_q   <= pending_d;
            primed_q    <= primed_d;
            for (int i = 0; i < NPORTS; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // bus_addr is registered from the next-state decode so it holds in IDLE.
    assign bus_enable = (state_q != S_IDLE);
    assign bus_addr   = bus_addr_q;
    assign cpu_grant  = cpu_grant_q;
    assign cpu_data   = cpu_data_q;
    assign pending    = pending_q;
    assign irq        = (pending_q != '0);
    assign irq_port   = irq_port_w;
    assign irq_data   = shadow_q[irq_port_w];

endmodule
`default_nettype wire
